md_unit: RTL and testbench

- Multi-cycle multiply/divide unit in the EX stage, alongside the integer ALU.
- Receives the same rs/rt operands (A, B) from the ID/EX register.
- Executes MULT/MULTU/DIV/DIVU/MTHI/MTLO and holds the architectural HI/LO registers.
- Raises busy so hazard logic can stall a later MFHI/MFLO or MD op.

---
 rtl/md_pkg.sv | 29 ++
 rtl/md_if.sv | 16 +
 rtl/md_div_iter.sv | 55 +++++
 rtl/md_unit.sv | 145 ++++++++++++++
 tb/tb_md_unit.sv | 190 +++++++++++++++++++
 5 files changed

// File: rtl/md_pkg.sv
// Shared definitions for the EX-stage multiply/divide unit.
package md_pkg;

  localparam int unsigned XLEN      = 32;
  localparam int unsigned OP_W      = 3;
  localparam int unsigned DIV_STEPS = 32;

  // MDOp encodings; 3'b111 is an unused slot that behaves like MD_NONE
  localparam logic [OP_W-1:0] MD_NONE  = 3'b000;
  localparam logic [OP_W-1:0] MD_MULT  = 3'b001;
  localparam logic [OP_W-1:0] MD_MULTU = 3'b010;
  localparam logic [OP_W-1:0] MD_DIV   = 3'b011;
  localparam logic [OP_W-1:0] MD_DIVU  = 3'b100;
  localparam logic [OP_W-1:0] MD_MTHI  = 3'b101;
  localparam logic [OP_W-1:0] MD_MTLO  = 3'b110;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_MUL,
    ST_DIV,
    ST_FIX
  } md_state_e;

  // Two's-complement negate when neg is set
  function automatic logic [XLEN-1:0] neg_if(input logic neg, input logic [XLEN-1:0] x);
    return neg ? XLEN'(-x) : x;
  endfunction

endpackage

// File: rtl/md_if.sv
// Issue/result bundle between the ID/EX pipeline and the multiply/divide unit.
interface md_if;
  import md_pkg::*;

  logic            start;
  logic [OP_W-1:0] MDOp;
  logic [XLEN-1:0] A;
  logic [XLEN-1:0] B;
  logic            flush;
  logic [XLEN-1:0] HI;
  logic [XLEN-1:0] LO;
  logic            busy;

  modport master (output start, MDOp, A, B, flush, input HI, LO, busy);
  modport slave  (input start, MDOp, A, B, flush, output HI, LO, busy);
endinterface

// File: rtl/md_div_iter.sv
// Restoring divider datapath: one quotient bit per enabled cycle on unsigned magnitudes.
module md_div_iter
  import md_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            load,
  input  logic            step,
  input  logic [XLEN-1:0] dividend,
  input  logic [XLEN-1:0] divisor,
  output logic [XLEN-1:0] quo,
  output logic [XLEN-1:0] rem,
  output logic            done_c
);

  localparam int unsigned ITER_W = $clog2(DIV_STEPS);

  logic [ITER_W-1:0] iter_q;
  logic [XLEN-1:0]   dvs_q;
  logic [XLEN:0]     shifted_c;
  logic [XLEN:0]     diff_c;

  // Shift the next dividend bit into the partial remainder and trial-subtract
  always_comb begin
    shifted_c = {rem, quo[XLEN-1]};
    diff_c    = shifted_c - {1'b0, dvs_q};
  end

  assign done_c = step && (iter_q == ITER_W'(DIV_STEPS - 1));

  // Quotient bits shift into the dividend register as dividend bits shift out
  always_ff @(posedge clk) begin
    if (rst) begin
      quo    <= '0;
      rem    <= '0;
      dvs_q  <= '0;
      iter_q <= '0;
    end else if (load) begin
      quo    <= dividend;
      rem    <= '0;
      dvs_q  <= divisor;
      iter_q <= '0;
    end else if (step) begin
      iter_q <= iter_q + ITER_W'(1);
      if (!diff_c[XLEN]) begin
        rem <= diff_c[XLEN-1:0];
        quo <= {quo[XLEN-2:0], 1'b1};
      end else begin
        rem <= shifted_c[XLEN-1:0];
        quo <= {quo[XLEN-2:0], 1'b0};
      end
    end
  end

endmodule

// File: rtl/md_unit.sv
// Multi-cycle multiply/divide unit holding the architectural HI/LO registers.
module md_unit
  import md_pkg::*;
#(
  parameter int unsigned MUL_LAT = 4
) (
  input logic clk,
  input logic rst,
  md_if.slave md
);

  localparam int unsigned CNT_W = (MUL_LAT > 1) ? $clog2(MUL_LAT) : 1;

  md_state_e         state_q, state_d;
  logic [CNT_W-1:0]  cnt_q;
  logic [2*XLEN-1:0] prod_q;
  logic              neg_quo_q, neg_rem_q;

  logic              accept_c, signed_c;
  logic [2*XLEN-1:0] prod_c;
  logic [XLEN-1:0]   mag_a_c, mag_b_c;
  logic              mul_load_c, mul_wr_c, cnt_dec_c;
  logic              div_load_c, div_step_c, fix_wr_c;
  logic              mthi_wr_c, mtlo_wr_c;
  logic [XLEN-1:0]   quo, rem;
  logic              div_done_c;

  // Operand conditioning: one sign-extended multiplier serves mult and multu
  always_comb begin
    accept_c = md.start && !md.busy && !md.flush;
    signed_c = (md.MDOp == MD_MULT) || (md.MDOp == MD_DIV);
    prod_c   = {{XLEN{signed_c & md.A[XLEN-1]}}, md.A} * {{XLEN{signed_c & md.B[XLEN-1]}}, md.B};
    mag_a_c  = neg_if(signed_c & md.A[XLEN-1], md.A);
    mag_b_c  = neg_if(signed_c & md.B[XLEN-1], md.B);
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // Next-state and datapath strobes; flush cancels everything in flight
  always_comb begin
    state_d    = state_q;
    mul_load_c = 1'b0;
    mul_wr_c   = 1'b0;
    cnt_dec_c  = 1'b0;
    div_load_c = 1'b0;
    div_step_c = 1'b0;
    fix_wr_c   = 1'b0;
    mthi_wr_c  = 1'b0;
    mtlo_wr_c  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (accept_c) begin
          case (md.MDOp)
            MD_MULT, MD_MULTU: begin
              state_d    = ST_MUL;
              mul_load_c = 1'b1;
            end
            MD_DIV, MD_DIVU: begin
              state_d    = ST_DIV;
              div_load_c = 1'b1;
            end
            MD_MTHI: mthi_wr_c = 1'b1;
            MD_MTLO: mtlo_wr_c = 1'b1;
            MD_NONE: ;
            default: ;
          endcase
        end
      end
      ST_MUL: begin
        if (cnt_q == '0) begin
          mul_wr_c = 1'b1;
          state_d  = ST_IDLE;
        end else begin
          cnt_dec_c = 1'b1;
        end
      end
      ST_DIV: begin
        div_step_c = 1'b1;
        if (div_done_c) state_d = ST_FIX;
      end
      ST_FIX: begin
        fix_wr_c = 1'b1;
        state_d  = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    if (md.flush) begin
      state_d  = ST_IDLE;
      mul_wr_c = 1'b0;
      fix_wr_c = 1'b0;
    end
  end

  // Multiply latch/counter, divide signs, busy flag and HI/LO
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q     <= '0;
      prod_q    <= '0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      md.busy   <= 1'b0;
      md.HI     <= '0;
      md.LO     <= '0;
    end else begin
      md.busy <= (state_d != ST_IDLE);
      if (mul_load_c) begin
        prod_q <= prod_c;
        cnt_q  <= CNT_W'(MUL_LAT - 1);
      end else if (cnt_dec_c) begin
        cnt_q <= cnt_q - CNT_W'(1);
      end
      if (div_load_c) begin
        neg_quo_q <= signed_c & (md.A[XLEN-1] ^ md.B[XLEN-1]);
        neg_rem_q <= signed_c & md.A[XLEN-1];
      end
      if (mthi_wr_c) md.HI <= md.A;
      if (mtlo_wr_c) md.LO <= md.A;
      if (mul_wr_c) begin
        md.HI <= prod_q[2*XLEN-1:XLEN];
        md.LO <= prod_q[XLEN-1:0];
      end
      if (fix_wr_c) begin
        md.HI <= neg_if(neg_rem_q, rem);
        md.LO <= neg_if(neg_quo_q, quo);
      end
    end
  end

  md_div_iter u_div (
    .clk     (clk),
    .rst     (rst),
    .load    (div_load_c),
    .step    (div_step_c),
    .dividend(mag_a_c),
    .divisor (mag_b_c),
    .quo     (quo),
    .rem     (rem),
    .done_c  (div_done_c)
  );

endmodule

// File: tb/tb_md_unit.sv
// Scoreboard bench for md_unit: stimulus pushes expected HI/LO, monitor checks on result presentation.
module tb_md_unit;
  import md_pkg::*;

  typedef struct {
    string       name;
    logic [31:0] hi;
    logic [31:0] lo;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  logic probe = 1'b0;
  logic prev_busy = 1'b0;
  int   total = 0;
  int   bad = 0;
  exp_t sb[$];

  always #5 clk = ~clk;

  md_if bus ();

  md_unit #(.MUL_LAT(4)) dut (
    .clk(clk),
    .rst(rst),
    .md (bus)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Monitor: a result is presented when busy falls, or when stimulus probes a zero-latency op
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if ((prev_busy && bus.busy === 1'b0) || probe) begin
        if (sb.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_result actual=%h_%h required=none", bus.HI, bus.LO);
        end else begin
          e = sb.pop_front();
          check({e.name, "_hi"}, bus.HI, e.hi);
          check({e.name, "_lo"}, bus.LO, e.lo);
        end
      end
      prev_busy = (bus.busy === 1'b1);
    end
  end

  // Drive one op for a single accepting edge, then scramble operands
  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    bus.start = 1'b1;
    bus.MDOp  = op;
    bus.A     = a;
    bus.B     = b;
    @(posedge clk); #1;
    bus.start = 1'b0;
    bus.MDOp  = MD_NONE;
    bus.A     = $urandom;
    bus.B     = $urandom;
  endtask

  task automatic wait_idle(input string name, input int lat);
    int n = 0;
    while (bus.busy === 1'b1 && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    check(name, 32'(n), 32'(lat));
  endtask

  task automatic pulse_probe();
    probe = 1'b1;
    @(negedge clk); #1;
    probe = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic run_op(input string name, input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] hi, input logic [31:0] lo,
                        input int lat);
    sb.push_back('{name, hi, lo});
    issue(op, a, b);
    check({name, "_busy_set"}, 32'(bus.busy), 32'd1);
    wait_idle({name, "_busy_cycles"}, lat);
  endtask

  initial begin
    rst       = 1'b1;
    bus.start = 1'b0;
    bus.flush = 1'b0;
    bus.MDOp  = MD_NONE;
    bus.A     = '0;
    bus.B     = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    check("reset_busy", 32'(bus.busy), 32'd0);
    sb.push_back('{"reset", 32'h0, 32'h0});
    pulse_probe();

    // mthi then mtlo back to back
    issue(MD_MTHI, 32'h12345678, 32'h0);
    check("mthi_busy", 32'(bus.busy), 32'd0);
    issue(MD_MTLO, 32'h9ABCDEF0, 32'h0);
    check("mtlo_busy", 32'(bus.busy), 32'd0);
    sb.push_back('{"mthi_mtlo", 32'h12345678, 32'h9ABCDEF0});
    pulse_probe();

    run_op("mult_m1x2",   MD_MULT,  32'hFFFFFFFF, 32'h2, 32'hFFFFFFFF, 32'hFFFFFFFE, 4);
    run_op("multu_m1x2",  MD_MULTU, 32'hFFFFFFFF, 32'h2, 32'h00000001, 32'hFFFFFFFE, 4);
    run_op("mult_m1xm1",  MD_MULT,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 32'h00000001, 4);
    run_op("multu_max",   MD_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 4);
    run_op("div_m7_2",    MD_DIV,   32'hFFFFFFF9, 32'h2, 32'hFFFFFFFF, 32'hFFFFFFFD, 33);
    run_op("divu_7_2",    MD_DIVU,  32'h7, 32'h2, 32'h1, 32'h3, 33);
    run_op("div_100_m7",  MD_DIV,   32'd100, 32'hFFFFFFF9, 32'h2, 32'hFFFFFFF2, 33);
    run_op("div_ovf",     MD_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h0, 32'h80000000, 33);
    run_op("divu_by0",    MD_DIVU,  32'h5, 32'h0, 32'h5, 32'hFFFFFFFF, 33);
    run_op("div_m5_by0",  MD_DIV,   32'hFFFFFFFB, 32'h0, 32'hFFFFFFFB, 32'h00000001, 33);

    // flush on the accepting edge blocks even mthi
    bus.flush = 1'b1;
    issue(MD_MTHI, 32'hAAAAAAAA, 32'h0);
    bus.flush = 1'b0;
    check("flush_start_busy", 32'(bus.busy), 32'd0);
    sb.push_back('{"flush_start", 32'hFFFFFFFB, 32'h00000001});
    pulse_probe();

    // flush mid-divide discards the partial result
    sb.push_back('{"flush_div", 32'hFFFFFFFB, 32'h00000001});
    issue(MD_DIV, 32'd100, 32'd7);
    repeat (9) begin @(posedge clk); #1; end
    bus.flush = 1'b1;
    @(posedge clk); #1;
    bus.flush = 1'b0;
    check("flush_div_busy", 32'(bus.busy), 32'd0);

    run_op("divu_after_flush", MD_DIVU, 32'h7, 32'h2, 32'h1, 32'h3, 33);

    // mthi issued while dividing is ignored
    sb.push_back('{"div_ign_mthi", 32'h2, 32'hE});
    issue(MD_DIV, 32'd100, 32'd7);
    repeat (4) begin @(posedge clk); #1; end
    bus.start = 1'b1;
    bus.MDOp  = MD_MTHI;
    bus.A     = 32'hDEADBEEF;
    @(posedge clk); #1;
    bus.start = 1'b0;
    bus.MDOp  = MD_NONE;
    check("div_ign_hi_held", bus.HI, 32'h1);
    wait_idle("div_ign_busy_rest", 28);

    // start held on the completion edge is ignored; the next cycle is accepted
    sb.push_back('{"mult_cmpl_start", 32'h0, 32'hF});
    issue(MD_MULT, 32'h3, 32'h5);
    repeat (3) begin @(posedge clk); #1; end
    bus.start = 1'b1;
    bus.MDOp  = MD_MTLO;
    bus.A     = 32'h55555555;
    @(posedge clk); #1;
    bus.start = 1'b0;
    bus.MDOp  = MD_NONE;
    check("cmpl_start_busy", 32'(bus.busy), 32'd0);
    sb.push_back('{"mtlo_after", 32'h0, 32'h55555555});
    issue(MD_MTLO, 32'h55555555, 32'h0);
    pulse_probe();

    // reset in the middle of a multiply
    sb.push_back('{"rst_mult", 32'h0, 32'h0});
    issue(MD_MULT, 32'hFFFFFFFF, 32'h2);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("rst_mult_busy", 32'(bus.busy), 32'd0);

    repeat (3) @(posedge clk);
    check("sb_empty", 32'(sb.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
